mem_loader: RTL and testbench

MEM_LOADER -- requirements
Module: mem_loader

---
 rtl/mem_loader_pkg.sv | 25 ++
 rtl/mem_loader_if.sv | 30 +++
 rtl/mem_loader_word_packer.sv | 51 +++++
 rtl/mem_loader.sv | 136 +++++++++++++
 tb/tb_mem_loader.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_loader_pkg
// Description : Shared helpers and constants for the byte-stream memory loader.
// Revision    : 1.0
// ============================================================================
package mem_loader_pkg;

    localparam int c_HDR_BYTES = 4;
    localparam int c_BUS_W     = 32;

    typedef logic [c_BUS_W-1:0] word32_t;

    // Ceiling log2; usable in constant expressions.
    function automatic int log2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_loader_if
// Description : Byte-stream input and memory-port bundle of the loader.
// Revision    : 1.0
// ============================================================================
interface mem_loader_if
    import mem_loader_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    word32_t          mem_addr;
    logic [WIDTH-1:0] mem_in;
    logic             mem_we;
    logic [WIDTH-1:0] mem_out;

    modport master (
        input  in_data, in_valid, mem_out,
        output in_ready, mem_addr, mem_in, mem_we
    );

    modport slave (
        output in_data, in_valid, mem_out,
        input  in_ready, mem_addr, mem_in, mem_we
    );
endinterface
`default_nettype wire

// File: rtl/mem_loader_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : word_packer
// Description : Little-endian byte-to-word assembler with stall and clear.
// Revision    : 1.0
// ============================================================================
module word_packer
    import mem_loader_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  clear,
    input  wire logic [7:0]            in_data,
    input  wire logic                  in_valid,
    output logic      [8*NBYTES-1:0]   word,
    output logic                       word_valid
);
    localparam int c_CNT_W = (NBYTES > 1) ? log2(NBYTES) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(NBYTES - 1);

    logic [c_CNT_W-1:0]  r_cnt;
    logic [8*NBYTES-1:0] r_bytes;
    logic [8*NBYTES-1:0] w_word;

    // The word output already includes the byte being accepted this cycle,
    // so the consumer sees the complete word in the same cycle as word_valid.
    always_comb begin
        w_word = r_bytes;
        if (in_valid) begin
            w_word[{r_cnt, 3'b000} +: 8] = in_data;
        end
    end

    assign word       = w_word;
    assign word_valid = in_valid && (r_cnt == c_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_bytes <= '0;
        end else if (clear) begin
            r_cnt   <= '0;
        end else if (in_valid) begin
            r_bytes <= w_word;
            r_cnt   <= (r_cnt == c_LAST) ? '0 : r_cnt + 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : mem_loader
// Description : Loads a length-prefixed byte stream into memory, then reads it
//               back to form a checksum before releasing the CPU from hold.
// Revision    : 1.0
// ============================================================================
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int WORD  = 1024
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mem_loader_if.master       bus,
    output logic               cpu_hold,
    output logic               done,
    output logic               error,
    output word32_t            checksum
);
    localparam int c_ADDR_W = log2(WORD);
    localparam int c_IDX_W  = c_ADDR_W + 1;
    localparam int c_NBYTES = WIDTH / 8;

    localparam logic [2:0] S_HDR    = 3'd0;
    localparam logic [2:0] S_DATA   = 3'd1;
    localparam logic [2:0] S_WRITE  = 3'd2;
    localparam logic [2:0] S_VERIFY = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;

    logic [2:0]         r_state;
    logic [c_IDX_W-1:0] r_index;
    word32_t            r_n;
    word32_t            r_checksum;

    word32_t            w_hdr_word;
    logic               w_hdr_valid;
    logic [WIDTH-1:0]   w_data_word;
    logic               w_data_valid;
    word32_t            w_idx_inc;
    word32_t            w_sum_term;

    word_packer #(.NBYTES(c_HDR_BYTES)) u_hdr_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (r_state != S_HDR),
        .in_data    (bus.in_data),
        .in_valid   (bus.in_valid && (r_state == S_HDR)),
        .word       (w_hdr_word),
        .word_valid (w_hdr_valid)
    );

    // Cleared while in HDR so every load starts on a word boundary.
    word_packer #(.NBYTES(c_NBYTES)) u_data_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (r_state == S_HDR),
        .in_data    (bus.in_data),
        .in_valid   (bus.in_valid && (r_state == S_DATA)),
        .word       (w_data_word),
        .word_valid (w_data_valid)
    );

    generate
        if (WIDTH >= 32) begin : g_sum_trunc
            assign w_sum_term = bus.mem_out[31:0];
        end else begin : g_sum_ext
            assign w_sum_term = {{(32 - WIDTH){1'b0}}, bus.mem_out};
        end
    endgenerate

    assign w_idx_inc = 32'(r_index) + 32'd1;

    assign bus.in_ready = (r_state == S_HDR) || (r_state == S_DATA);
    assign bus.mem_we   = (r_state == S_WRITE);
    assign bus.mem_in   = w_data_word;
    assign bus.mem_addr = 32'(r_index[c_ADDR_W-1:0]);
    assign done         = (r_state == S_DONE);
    assign error        = (r_state == S_ERR);
    assign cpu_hold     = (r_state != S_DONE);
    assign checksum     = r_checksum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_HDR;
            r_index    <= '0;
            r_n        <= '0;
            r_checksum <= '0;
        end else begin
            case (r_state)
                S_HDR: begin
                    if (w_hdr_valid) begin
                        r_n     <= w_hdr_word;
                        r_index <= '0;
                        if ((w_hdr_word == 32'd0) || (w_hdr_word > 32'(WORD))) begin
                            r_state <= S_ERR;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_data_valid) begin
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (w_idx_inc < r_n) begin
                        r_index <= r_index + 1'b1;
                        r_state <= S_DATA;
                    end else begin
                        r_index <= '0;
                        r_state <= S_VERIFY;
                    end
                end
                S_VERIFY: begin
                    r_checksum <= r_checksum + w_sum_term;
                    if (w_idx_inc == r_n) begin
                        r_state <= S_DONE;
                    end else begin
                        r_index <= r_index + 1'b1;
                    end
                end
                S_DONE, S_ERR: begin
                    r_state <= r_state;
                end
                default: begin
                    r_state <= S_HDR;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_loader
// Description : Randomised scoreboard bench for mem_loader with behavioural RAM.
// Revision    : 1.0
// ============================================================================
module tb_mem_loader;
    import mem_loader_pkg::*;

    localparam int WIDTH  = 32;
    localparam int WORD   = 1024;
    localparam int ADDR_W = 10;

    typedef struct {
        logic [31:0]      addr;
        logic [WIDTH-1:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        done, error, cpu_hold;
    logic [31:0] checksum;

    mem_loader_if #(.WIDTH(WIDTH)) bus ();

    mem_loader #(.WIDTH(WIDTH), .WORD(WORD)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error),
        .checksum (checksum)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] ram [WORD];
    assign bus.mem_out = ram[bus.mem_addr[ADDR_W-1:0]];
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr[ADDR_W-1:0]] <= bus.mem_in;
    end

    int  errors    = 0;
    int  checks    = 0;
    int  writes    = 0;
    int  last_sent = 0;
    int  we_seen   = 0;
    wr_t exp_q [$];
    wr_t e;
    bit  due;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: write timing, address range and scoreboard data.
    always @(negedge clk) begin
        if (rst) begin
            due = (last_sent != we_seen);
            if (bus.mem_we || due) begin
                chk("we_one_cycle_after_last_byte", 32'(bus.mem_we), 32'(due));
                if (due) we_seen++;
            end
            if (bus.mem_we) begin
                writes++;
                chk("in_ready_low_in_write", 32'(bus.in_ready), 32'd0);
                chk("addr_in_range", 32'(bus.mem_addr < WORD), 32'd1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %h data %h, none expected", bus.mem_addr, bus.mem_in);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", bus.mem_addr, e.addr);
                    chk("wr_data", 32'(bus.mem_in), 32'(e.data));
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit last);
        bit acc;
        int t;
        acc = 1'b0;
        t   = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            t++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL byte_accept_timeout: byte %h never accepted", b);
        end else if (last) begin
            last_sent++;
        end
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic gap(input int maxg);
        int k;
        k = $urandom_range(0, maxg);
        if (k > 0) begin
            repeat (k) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_hdr(input logic [31:0] n);
        for (int b = 0; b < 4; b++) send_byte(n[8*b +: 8], 1'b0);
    endtask

    task automatic send_word(input logic [31:0] idx, input logic [WIDTH-1:0] d, input int maxg);
        wr_t w;
        w.addr = idx;
        w.data = d;
        exp_q.push_back(w);
        for (int b = 0; b < WIDTH/8; b++) begin
            gap(maxg);
            send_byte(d[8*b +: 8], b == WIDTH/8 - 1);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_checksum", checksum, 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    task automatic wait_end(input int limit);
        int t;
        t = 0;
        while (!done && !error && t < limit) begin
            @(posedge clk);
            t++;
        end
        #1;
    endtask

    logic [31:0]      sum;
    logic [31:0]      csum_hold;
    logic [WIDTH-1:0] w;
    logic [WIDTH-1:0] keep [3];
    int               w0;

    initial begin
        rst          = 1'b1;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        #2;
        do_reset();

        // Two-word directed load.
        send_hdr(32'd2);
        send_word(32'd0, 32'h12345678, 0);
        send_word(32'd1, 32'hDEADBEEF, 0);
        sum = 32'h12345678 + 32'hDEADBEEF;
        wait_end(100);
        chk("a_done", 32'(done), 32'd1);
        chk("a_cpu_hold", 32'(cpu_hold), 32'd0);
        chk("a_in_ready", 32'(bus.in_ready), 32'd0);
        chk("a_error", 32'(error), 32'd0);
        chk("a_checksum", checksum, sum);
        chk("a_mem0", 32'(ram[0]), 32'h12345678);
        chk("a_mem1", 32'(ram[1]), 32'hDEADBEEF);

        // Bytes offered after completion must be ignored.
        csum_hold    = checksum;
        w0           = writes;
        bus.in_data  = 8'hFF;
        bus.in_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("post_done_checksum", checksum, csum_hold);
        chk("post_done_no_write", 32'(writes - w0), 32'd0);
        chk("post_done_sticky", 32'(done), 32'd1);

        // Out-of-range headers.
        for (int k = 0; k < 2; k++) begin
            do_reset();
            w0 = writes;
            send_hdr(k == 0 ? 32'd0 : 32'd1025);
            wait_end(20);
            bus.in_data  = 8'h5A;
            bus.in_valid = 1'b1;
            repeat (5) @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            chk("err_error", 32'(error), 32'd1);
            chk("err_cpu_hold", 32'(cpu_hold), 32'd1);
            chk("err_in_ready", 32'(bus.in_ready), 32'd0);
            chk("err_done", 32'(done), 32'd0);
            chk("err_no_write", 32'(writes - w0), 32'd0);
        end

        // Full-depth random load with random valid gaps.
        do_reset();
        w0  = writes;
        sum = 32'd0;
        send_hdr(32'(WORD));
        for (int i = 0; i < WORD; i++) begin
            w   = WIDTH'($urandom);
            sum = sum + 32'(w);
            send_word(32'(i), w, 2);
        end
        wait_end(3000);
        chk("full_writes", 32'(writes - w0), 32'(WORD));
        chk("full_done", 32'(done), 32'd1);
        chk("full_checksum", checksum, sum);

        // Reset in the middle of word 3, then a one-word reload.
        do_reset();
        send_hdr(32'd5);
        for (int i = 0; i < 3; i++) begin
            keep[i] = WIDTH'($urandom);
            send_word(32'(i), keep[i], 1);
        end
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("mid_pending_writes", 32'(exp_q.size()), 32'd0);
        do_reset();
        w0 = writes;
        send_hdr(32'd1);
        send_word(32'd0, 32'hA5A5A5A5, 1);
        wait_end(100);
        chk("reload_writes", 32'(writes - w0), 32'd1);
        chk("reload_mem0", 32'(ram[0]), 32'hA5A5A5A5);
        chk("reload_mem1", 32'(ram[1]), 32'(keep[1]));
        chk("reload_mem2", 32'(ram[2]), 32'(keep[2]));
        chk("reload_done", 32'(done), 32'd1);
        chk("reload_checksum", checksum, 32'hA5A5A5A5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete, errors=%0d", errors);
        $fatal(1);
    end
endmodule
`default_nettype wire
